scancode_decoder: RTL and testbench
===================================

SCANCODE_DECODER -- requirements
Module: scancode_decoder

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed at 8 bits.
REQ-002 Port clk, input, 1 bit: single system clock, rising-edge active.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port scan_code, input, 8 bits: PS/2 Set-2 scancode byte, held stable by the upstream receiver between frames.
REQ-005 Port ascii_code, output, 8 bits: combinational ASCII translation of scan_code.
REQ-006 Port ascii_code_r, output, 8 bits: registered copy of ascii_code.

Function
REQ-007 ascii_code SHALL be a purely combinational function of scan_code, with zero-cycle latency. The upstream block samples it one clk after scan_code changes.
REQ-008 ascii_code_r SHALL load ascii_code on every rising clk edge, giving 1-cycle latency.
REQ-009 Letters SHALL map to uppercase ASCII, with the following scancode-to-character pairs:
- 1C->'A', 32->'B', 21->'C', 23->'D', 24->'E', 2B->'F', 34->'G'
- 33->'H', 43->'I', 3B->'J', 42->'K', 4B->'L', 3A->'M', 31->'N'
- 44->'O', 4D->'P', 15->'Q', 2D->'R', 1B->'S', 2C->'T', 3C->'U'
- 2A->'V', 1D->'W', 22->'X', 35->'Y', 1A->'Z'
REQ-010 Digits SHALL map as follows:
- 45->'0', 16->'1', 1E->'2', 26->'3', 25->'4'
- 2E->'5', 36->'6', 3D->'7', 3E->'8', 46->'9'
REQ-011 Control keys SHALL map as follows:
- 29->0x20 (space), 5A->0x0D (Enter), 66->0x08 (Backspace)
- 76->0x1B (Esc), 0D->0x09 (Tab)
REQ-012 Punctuation SHALL map as follows:
- 41->',', 49->'.', 4A->'/', 4C->';', 52->0x27 (apostrophe)
- 4E->'-', 55->'=', 54->'[', 5B->']', 5D->0x5C (backslash), 0E->'`'
REQ-013 Every other scancode SHALL produce 0x00. This includes 0x00, 0xF0 (break prefix), 0xE0 (extended prefix), 0x12/0x59 (shift), 0x14 (ctrl), 0x11 (alt), 0x58 (caps lock), F-keys and all undefined codes.
REQ-014 The decoder SHALL hold no shift, caps or break state; modifier handling is the upstream block's responsibility.
REQ-015 The mapping SHALL be fully specified for all 256 input values, so that no latches are inferred.
REQ-016 While scan_code is stable, the decoder SHALL leave ascii_code stable and keep ascii_code_r equal to it from one cycle later onward.

Reset
REQ-017 While rst_n=0, ascii_code_r SHALL be 0x00, asynchronously and regardless of clk.
REQ-018 Reset SHALL NOT affect ascii_code, which keeps tracking scan_code during reset.
REQ-019 On rst_n deassertion, ascii_code_r SHALL take the current translation at the first rising clk edge.
REQ-020 If reset is asserted mid-operation, it SHALL clear ascii_code_r within the same cycle, with no pending update afterward.

Verification
REQ-021 Letter mapping: drive scan_code=0x1C, then 0x1A -> ascii_code=0x41 then 0x5A immediately; ascii_code_r follows one clk later.
REQ-022 Digit and control mapping: drive 0x45, 0x46, 0x29, 0x5A, 0x66 -> outputs 0x30, 0x39, 0x20, 0x0D, 0x08.
REQ-023 Non-character codes: drive 0xF0, 0xE0, 0x12, 0x58, 0x00, 0xFF -> ascii_code=0x00 for each.
REQ-024 Exhaustive sweep over 0x00-0xFF: ascii_code matches the REQ-009 to REQ-013 table, and no output is X or Z.
REQ-025 Reset:
- Setup: scan_code=0x1C with ascii_code_r=0x41.
- Stimulus: assert rst_n=0 between clk edges.
- Required: ascii_code_r=0x00 at once, and ascii_code stays 0x41.
- After deassertion: ascii_code_r=0x41 at the next rising clk edge.
REQ-026 Upstream timing:
- Stimulus: change scan_code from 0x00 to 0x24 one cycle before a sampling edge.
- Required: the sample taken at that edge equals 0x45.

Source files
------------

// File: rtl/scancode_decoder.sv
// PS/2 Set-2 scancode to ASCII translator.
// Stateless lookup with a single registered copy of the result.
module scancode_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] scan_code,
  output logic [7:0] ascii_code,
  output logic [7:0] ascii_code_r
);

  always_comb begin
    ascii_code = 8'h00;
    unique case (scan_code)
      8'h1C: ascii_code = "A";
      8'h32: ascii_code = "B";
      8'h21: ascii_code = "C";
      8'h23: ascii_code = "D";
      8'h24: ascii_code = "E";
      8'h2B: ascii_code = "F";
      8'h34: ascii_code = "G";
      8'h33: ascii_code = "H";
      8'h43: ascii_code = "I";
      8'h3B: ascii_code = "J";
      8'h42: ascii_code = "K";
      8'h4B: ascii_code = "L";
      8'h3A: ascii_code = "M";
      8'h31: ascii_code = "N";
      8'h44: ascii_code = "O";
      8'h4D: ascii_code = "P";
      8'h15: ascii_code = "Q";
      8'h2D: ascii_code = "R";
      8'h1B: ascii_code = "S";
      8'h2C: ascii_code = "T";
      8'h3C: ascii_code = "U";
      8'h2A: ascii_code = "V";
      8'h1D: ascii_code = "W";
      8'h22: ascii_code = "X";
      8'h35: ascii_code = "Y";
      8'h1A: ascii_code = "Z";
      8'h45: ascii_code = "0";
      8'h16: ascii_code = "1";
      8'h1E: ascii_code = "2";
      8'h26: ascii_code = "3";
      8'h25: ascii_code = "4";
      8'h2E: ascii_code = "5";
      8'h36: ascii_code = "6";
      8'h3D: ascii_code = "7";
      8'h3E: ascii_code = "8";
      8'h46: ascii_code = "9";
      8'h29: ascii_code = 8'h20;
      8'h5A: ascii_code = 8'h0D;
      8'h66: ascii_code = 8'h08;
      8'h76: ascii_code = 8'h1B;
      8'h0D: ascii_code = 8'h09;
      8'h41: ascii_code = ",";
      8'h49: ascii_code = ".";
      8'h4A: ascii_code = "/";
      8'h4C: ascii_code = ";";
      8'h52: ascii_code = 8'h27;
      8'h4E: ascii_code = "-";
      8'h55: ascii_code = "=";
      8'h54: ascii_code = "[";
      8'h5B: ascii_code = "]";
      8'h5D: ascii_code = 8'h5C;
      8'h0E: ascii_code = 8'h60;
      default: ascii_code = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ascii_code_r <= 8'h00;
    else
      ascii_code_r <= ascii_code;
  end

endmodule

// File: tb/tb_scancode_decoder.sv
// Directed bench for scancode_decoder.
// Reference table built from scancode/character pairs.
module tb_scancode_decoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] scan_code;
    logic [7:0] ascii_code;
    logic [7:0] ascii_code_r;

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_tab [256];

    localparam int NMAP = 52;
    logic [15:0] map_tab [NMAP] = '{
        {8'h1C, "A"}, {8'h32, "B"}, {8'h21, "C"}, {8'h23, "D"},
        {8'h24, "E"}, {8'h2B, "F"}, {8'h34, "G"}, {8'h33, "H"},
        {8'h43, "I"}, {8'h3B, "J"}, {8'h42, "K"}, {8'h4B, "L"},
        {8'h3A, "M"}, {8'h31, "N"}, {8'h44, "O"}, {8'h4D, "P"},
        {8'h15, "Q"}, {8'h2D, "R"}, {8'h1B, "S"}, {8'h2C, "T"},
        {8'h3C, "U"}, {8'h2A, "V"}, {8'h1D, "W"}, {8'h22, "X"},
        {8'h35, "Y"}, {8'h1A, "Z"},
        {8'h45, 8'h30}, {8'h16, 8'h31}, {8'h1E, 8'h32},
        {8'h26, 8'h33}, {8'h25, 8'h34}, {8'h2E, 8'h35},
        {8'h36, 8'h36}, {8'h3D, 8'h37}, {8'h3E, 8'h38},
        {8'h46, 8'h39},
        {8'h29, 8'h20}, {8'h5A, 8'h0D}, {8'h66, 8'h08},
        {8'h76, 8'h1B}, {8'h0D, 8'h09},
        {8'h41, 8'h2C}, {8'h49, 8'h2E}, {8'h4A, 8'h2F},
        {8'h4C, 8'h3B}, {8'h52, 8'h27}, {8'h4E, 8'h2D},
        {8'h55, 8'h3D}, {8'h54, 8'h5B}, {8'h5B, 8'h5D},
        {8'h5D, 8'h5C}, {8'h0E, 8'h60}
    };

    scancode_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_code    (scan_code),
        .ascii_code   (ascii_code),
        .ascii_code_r (ascii_code_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Drive at negedge, check comb output, then registered after posedge.
    task automatic apply(input logic [7:0] sc, input logic [7:0] exp);
        @(negedge clk);
        scan_code = sc;
        #1;
        check($sformatf("comb_%02h", sc), ascii_code, exp);
        @(posedge clk);
        #1;
        check($sformatf("reg_%02h", sc), ascii_code_r, exp);
    endtask

    initial begin
        logic [7:0] nonchar [6];
        logic [7:0] dig_in [5];
        logic [7:0] dig_ex [5];
        nonchar = '{8'hF0, 8'hE0, 8'h12, 8'h58, 8'h00, 8'hFF};
        dig_in  = '{8'h45, 8'h46, 8'h29, 8'h5A, 8'h66};
        dig_ex  = '{8'h30, 8'h39, 8'h20, 8'h0D, 8'h08};

        for (int i = 0; i < 256; i++) ref_tab[i] = 8'h00;
        for (int i = 0; i < NMAP; i++)
            ref_tab[map_tab[i][15:8]] = map_tab[i][7:0];

        rst_n = 1'b0;
        scan_code = 8'h1C;
        #12;
        check("reset_reg", ascii_code_r, 8'h00);
        check("reset_comb", ascii_code, 8'h41);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge", ascii_code_r, 8'h41);

        apply(8'h1C, 8'h41);
        apply(8'h1A, 8'h5A);
        for (int i = 0; i < 5; i++) apply(dig_in[i], dig_ex[i]);
        for (int i = 0; i < 6; i++) apply(nonchar[i], 8'h00);

        // Exhaustive combinational sweep.
        for (int i = 0; i < 256; i++) begin
            scan_code = 8'(i);
            #1;
            if ($isunknown(ascii_code))
                check($sformatf("xz_%02h", i), 8'hXX, ref_tab[i]);
            else
                check($sformatf("sweep_%02h", i), ascii_code, ref_tab[i]);
        end

        // Mid-operation reset.
        apply(8'h1C, 8'h41);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_reg", ascii_code_r, 8'h00);
        check("mid_rst_comb", ascii_code, 8'h41);
        @(posedge clk);
        #1;
        check("held_rst_reg", ascii_code_r, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_no_update", ascii_code_r, 8'h00);
        @(posedge clk);
        #1;
        check("rel_edge", ascii_code_r, 8'h41);

        // Upstream timing: change one cycle before the sampling edge.
        apply(8'h00, 8'h00);
        scan_code = 8'h24;
        @(posedge clk);
        #1;
        check("upstream", ascii_code_r, 8'h45);
        @(posedge clk);
        #1;
        check("stable", ascii_code_r, 8'h45);
        check("stable_comb", ascii_code, 8'h45);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
